// File: rtl/ah_pl2ddr_data_capture.sv
// Sample capture, LSB-first packing into 32-bit words and a 1024x32 ring buffer for the PL-to-DDR path.
// Optional test-pattern counter enabled by defining AH_PL2DDR_CAPTURE_TESTMODE_EN.
module ah_pl2ddr_data_capture #(
  parameter int unsigned DATA_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_sample_valid,
  input  logic [DATA_WIDTH-1:0] in_sample_data,
  input  logic                  in_rst_data,
  input  logic                  in_enable_active,
  input  logic                  in_enable_ovw,
  input  logic                  in_data_overwrite,
  input  logic [DATA_WIDTH-1:0] in_data_overwrite_value,
  input  logic                  in_fill_data,
  input  logic [31:0]           in_undersampling,
  input  logic                  in_testmode,
  input  logic                  in_rd_en,
  output logic [31:0]           out_rd_data,
  output logic                  out_rd_valid,
  output logic [9:0]            out_data_available,
  output logic [31:0]           out_data_index,
  output logic [5:0]            out_data_pending,
  output logic [9:0]            out_bram_addr_read,
  output logic [9:0]            out_bram_addr_write,
  output logic                  out_data_error
);

  localparam int unsigned SPW       = 32 / DATA_WIDTH;
  localparam logic [5:0]  LAST_SLOT = 6'(SPW - 1);
  localparam logic [9:0]  MAX_WORDS = 10'd1023;

  logic [31:0]           r_mem [1024];
  logic [31:0]           r_rd_data;
  logic                  r_rd_valid;
  logic [9:0]            r_wptr;
  logic [9:0]            r_rptr;
  logic [9:0]            r_available;
  logic [31:0]           r_index;
  logic [5:0]            r_pending;
  logic [31:0]           r_pack;
  logic [31:0]           r_us_cnt;
  logic                  r_error;

  logic                  w_run;
  logic                  w_fill;
  logic                  w_qual;
  logic                  w_accept;
  logic                  w_insert;
  logic [DATA_WIDTH-1:0] w_value;
  logic [31:0]           w_word;
  logic                  w_word_done;
  logic                  w_full;
  logic                  w_wr;
  logic                  w_rd;

`ifdef AH_PL2DDR_CAPTURE_TESTMODE_EN
  logic [DATA_WIDTH-1:0] r_tm_cnt;
`else
  logic                  w_unused_testmode;
  assign w_unused_testmode = in_testmode;
`endif

  assign w_run    = rst & ~in_rst_data;
  assign w_fill   = in_fill_data & (r_pending != 6'd0);
  // Fill owns the insert slot; live samples are not qualified while padding.
  assign w_qual   = in_sample_valid & (in_enable_active | in_enable_ovw) & ~w_fill;
  assign w_accept = w_qual & (r_us_cnt == 32'd0);
  assign w_insert = w_fill | w_accept;

  always_comb begin
    w_value = in_sample_data;
`ifdef AH_PL2DDR_CAPTURE_TESTMODE_EN
    if (in_testmode) w_value = r_tm_cnt;
`endif
    if (w_fill || in_data_overwrite) w_value = in_data_overwrite_value;
  end

  // Slots above r_pending are always zero, so OR-ing in the new sample is enough.
  assign w_word      = r_pack | (32'(w_value) << (32'(r_pending) * DATA_WIDTH));
  assign w_word_done = w_insert & (r_pending == LAST_SLOT);
  assign w_full      = (r_available == MAX_WORDS);
  assign w_wr        = w_run & w_word_done & ~w_full;
  assign w_rd        = w_run & in_rd_en & (r_available != 10'd0);

  always_ff @(posedge clk) begin
    if (!rst || in_rst_data) begin
      r_rd_valid  <= 1'b0;
      r_wptr      <= 10'd0;
      r_rptr      <= 10'd0;
      r_available <= 10'd0;
      r_index     <= 32'd0;
      r_pending   <= 6'd0;
      r_pack      <= 32'd0;
      r_us_cnt    <= 32'd0;
      r_error     <= 1'b0;
`ifdef AH_PL2DDR_CAPTURE_TESTMODE_EN
      r_tm_cnt    <= '0;
`endif
    end else begin
      if (w_qual) r_us_cnt <= (r_us_cnt == 32'd0) ? in_undersampling : r_us_cnt - 32'd1;
      if (w_accept && (r_index != 32'hFFFF_FFFF)) r_index <= r_index + 32'd1;
`ifdef AH_PL2DDR_CAPTURE_TESTMODE_EN
      if (w_accept) r_tm_cnt <= r_tm_cnt + 1'b1;
`endif
      if (w_insert) begin
        if (w_word_done) begin
          r_pack    <= 32'd0;
          r_pending <= 6'd0;
        end else begin
          r_pack    <= w_word;
          r_pending <= r_pending + 6'd1;
        end
      end
      if (w_word_done && w_full) r_error <= 1'b1;
      if (w_wr) r_wptr <= r_wptr + 10'd1;
      if (w_rd) r_rptr <= r_rptr + 10'd1;
      case ({w_wr, w_rd})
        2'b10:   r_available <= r_available + 10'd1;
        2'b01:   r_available <= r_available - 10'd1;
        default: r_available <= r_available;
      endcase
      r_rd_valid <= w_rd;
    end
  end

  // Plain simple-dual-port block with registered read; contents survive clears.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= w_word;
    if (w_rd) r_rd_data <= r_mem[r_rptr];
  end

  assign out_rd_data         = r_rd_data;
  assign out_rd_valid        = r_rd_valid;
  assign out_data_available  = r_available;
  assign out_data_index      = r_index;
  assign out_data_pending    = r_pending;
  assign out_bram_addr_read  = r_rptr;
  assign out_bram_addr_write = r_wptr;
  assign out_data_error      = r_error;

endmodule

// File: tb/tb_ah_pl2ddr_data_capture.sv
// Bench for ah_pl2ddr_data_capture at DATA_WIDTH=8: directed scenarios plus random traffic
// checked every cycle against a queue-based reference model.
module tb_ah_pl2ddr_data_capture;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_sample_valid;
  logic [DW-1:0] in_sample_data;
  logic          in_rst_data;
  logic          in_enable_active;
  logic          in_enable_ovw;
  logic          in_data_overwrite;
  logic [DW-1:0] in_data_overwrite_value;
  logic          in_fill_data;
  logic [31:0]   in_undersampling;
  logic          in_testmode;
  logic          in_rd_en;
  logic [31:0]   out_rd_data;
  logic          out_rd_valid;
  logic [9:0]    out_data_available;
  logic [31:0]   out_data_index;
  logic [5:0]    out_data_pending;
  logic [9:0]    out_bram_addr_read;
  logic [9:0]    out_bram_addr_write;
  logic          out_data_error;

  always #5 clk = ~clk;

  ah_pl2ddr_data_capture #(.DATA_WIDTH(DW)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .in_sample_valid         (in_sample_valid),
    .in_sample_data          (in_sample_data),
    .in_rst_data             (in_rst_data),
    .in_enable_active        (in_enable_active),
    .in_enable_ovw           (in_enable_ovw),
    .in_data_overwrite       (in_data_overwrite),
    .in_data_overwrite_value (in_data_overwrite_value),
    .in_fill_data            (in_fill_data),
    .in_undersampling        (in_undersampling),
    .in_testmode             (in_testmode),
    .in_rd_en                (in_rd_en),
    .out_rd_data             (out_rd_data),
    .out_rd_valid            (out_rd_valid),
    .out_data_available      (out_data_available),
    .out_data_index          (out_data_index),
    .out_data_pending        (out_data_pending),
    .out_bram_addr_read      (out_bram_addr_read),
    .out_bram_addr_write     (out_bram_addr_write),
    .out_data_error          (out_data_error)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Reference model: buffer as a queue of words, partial word as a queue of samples.
  logic [31:0]   m_buf[$];
  logic [DW-1:0] m_part[$];
  longint        m_idx;
  longint        m_skip;
  bit            m_err;
  int            m_wcnt;
  int            m_rcnt;
  bit            m_rv;
  logic [31:0]   m_rd;
  logic [DW-1:0] m_tm;

  task automatic model_clear();
    m_buf.delete();
    m_part.delete();
    m_idx  = 0;
    m_skip = 0;
    m_err  = 0;
    m_wcnt = 0;
    m_rcnt = 0;
    m_rv   = 0;
    m_tm   = '0;
  endtask

  task automatic model_tick();
    bit            rd;
    bit            full;
    bit            ins;
    logic [DW-1:0] val;
    logic [31:0]   w;
    if (!rst || in_rst_data) begin
      model_clear();
      return;
    end
    rd   = in_rd_en && (m_buf.size() > 0);
    full = (m_buf.size() == 1023);
    ins  = 0;
    val  = '0;
    if (in_fill_data && m_part.size() > 0) begin
      ins = 1;
      val = in_data_overwrite_value;
    end else if (in_sample_valid && (in_enable_active || in_enable_ovw)) begin
      if (m_skip == 0) begin
        ins    = 1;
        m_skip = longint'(in_undersampling);
        val    = in_sample_data;
`ifdef AH_PL2DDR_CAPTURE_TESTMODE_EN
        if (in_testmode) val = m_tm;
        m_tm = m_tm + 1'b1;
`endif
        if (in_data_overwrite) val = in_data_overwrite_value;
        if (m_idx < 64'hFFFF_FFFF) m_idx++;
      end else begin
        m_skip--;
      end
    end
    m_rv = rd;
    if (rd) begin
      m_rd = m_buf.pop_front();
      m_rcnt++;
    end
    if (ins) begin
      m_part.push_back(val);
      if (m_part.size() == 32 / DW) begin
        w = '0;
        for (int i = 0; i < 32 / DW; i++) w[i*DW +: DW] = m_part[i];
        m_part.delete();
        if (full) m_err = 1;
        else begin
          m_buf.push_back(w);
          m_wcnt++;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_tick();
    #1;
    check("available", 32'(out_data_available), 32'(m_buf.size()));
    check("pending", 32'(out_data_pending), 32'(m_part.size()));
    check("index", out_data_index, m_idx[31:0]);
    check("wptr", 32'(out_bram_addr_write), 32'(m_wcnt % 1024));
    check("rptr", 32'(out_bram_addr_read), 32'(m_rcnt % 1024));
    check("error", 32'(out_data_error), 32'(m_err));
    check("rd_valid", 32'(out_rd_valid), 32'(m_rv));
    if (m_rv) check("rd_data", out_rd_data, m_rd);
  endtask

  task automatic idle_inputs();
    in_sample_valid         = 0;
    in_sample_data          = '0;
    in_rst_data             = 0;
    in_data_overwrite       = 0;
    in_data_overwrite_value = '0;
    in_fill_data            = 0;
    in_rd_en                = 0;
  endtask

  task automatic sample(input logic [DW-1:0] d, input logic rd);
    in_sample_valid = 1;
    in_sample_data  = d;
    in_rd_en        = rd;
    tick();
    in_sample_valid = 0;
    in_rd_en        = 0;
  endtask

  task automatic clear_data();
    idle_inputs();
    in_rst_data = 1;
    tick();
    tick();
    in_rst_data = 0;
  endtask

  initial begin
    rst              = 0;
    in_enable_active = 1;
    in_enable_ovw    = 0;
    in_undersampling = 0;
    in_testmode      = 0;
    idle_inputs();
    model_clear();
    repeat (3) tick();
    rst = 1;
    tick();
    check("reset_avail", 32'(out_data_available), 32'd0);

    // Four bytes pack LSB-first into one word.
    sample(8'h11, 0);
    sample(8'h22, 0);
    sample(8'h33, 0);
    sample(8'h44, 0);
    check("t1_index", out_data_index, 32'd4);
    in_rd_en = 1;
    tick();
    in_rd_en = 0;
    tick();
    check("t1_word", out_rd_data, 32'h4433_2211);

    // Undersampling keeps one in three.
    clear_data();
    in_undersampling = 2;
    for (int i = 0; i < 9; i++) sample(8'(i), 0);
    check("t2_index", out_data_index, 32'd3);
    check("t2_pending", 32'(out_data_pending), 32'd3);
    in_undersampling = 0;

    // Fill pads a partial word, then does nothing once pending is zero.
    clear_data();
    sample(8'hAA, 0);
    in_fill_data = 1;
    in_data_overwrite_value = 8'h00;
    repeat (5) tick();
    in_fill_data = 0;
    check("t3_index", out_data_index, 32'd1);
    check("t3_avail", 32'(out_data_available), 32'd1);
    in_rd_en = 1;
    tick();
    in_rd_en = 0;
    check("t3_word", out_rd_data, 32'h0000_00AA);

    // Overflow: 1024 words without reading.
    clear_data();
    for (int i = 0; i < 1024 * 4; i++) sample(8'($urandom), 0);
    check("t4_avail", 32'(out_data_available), 32'd1023);
    check("t4_error", 32'(out_data_error), 32'd1);
    clear_data();
    check("t4_clr_error", 32'(out_data_error), 32'd0);

    // Word completes while a read is taken.
    for (int i = 0; i < 23; i++) sample(8'($urandom), 0);
    sample(8'h5A, 1);
    check("t5_avail", 32'(out_data_available), 32'd5);
    tick();
    for (int i = 0; i < 5; i++) begin
      in_rd_en = 1;
      tick();
    end
    in_rd_en = 1;
    tick();
    in_rd_en = 0;
    tick();
    check("t5_empty_rv", 32'(out_rd_valid), 32'd0);

    // Mid-word reset.
    sample(8'h01, 0);
    sample(8'h02, 0);
    rst = 0;
    tick();
    rst = 1;
    check("t6_pending", 32'(out_data_pending), 32'd0);
    check("t6_index", out_data_index, 32'd0);

`ifdef AH_PL2DDR_CAPTURE_TESTMODE_EN
    in_testmode = 1;
    for (int i = 0; i < 4; i++) sample(8'hFF, 0);
    in_rd_en = 1;
    tick();
    in_rd_en = 0;
    check("tm_word", out_rd_data, 32'h0302_0100);
    in_testmode = 0;
`endif

    // Random traffic.
    for (int c = 0; c < 6000; c++) begin
      if (($urandom % 200) == 0) in_undersampling = $urandom % 3;
      in_enable_active        = ($urandom % 8) != 0;
      in_enable_ovw           = ($urandom % 8) == 0;
      in_data_overwrite       = ($urandom % 10) == 0;
      in_data_overwrite_value = 8'($urandom);
      in_sample_data          = 8'($urandom);
      in_fill_data            = ($urandom % 20) == 0;
      in_sample_valid         = !in_fill_data && (($urandom % 4) != 0);
      in_rd_en                = ($urandom % 5) < ((c / 1500) % 2 == 0 ? 1 : 3);
      in_rst_data             = ($urandom % 300) == 0;
      rst                     = ($urandom % 500) != 0;
`ifdef AH_PL2DDR_CAPTURE_TESTMODE_EN
      in_testmode             = $urandom % 2;
`endif
      tick();
    end
    rst = 1;
    idle_inputs();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
